ysyx_22040895_idu_stage: RTL and testbench
==========================================

Name: ysyx_22040895_idu_stage

Overview:
- Registered, handshaked instruction-decode stage between IFU and EXU.
- Accepts {inst, pc} from IFU over valid/ready and performs full field extraction.
- Classifies the format (R/I/S/B/U/J), generates the complete sign-extended immediate (XLEN) and flags illegal opcodes.
- A 2-entry skid buffer sustains one instruction per cycle under backpressure; a flush input discards in-flight entries on a redirect.

Parameters:
- XLEN, 64, data/PC/immediate width.
- ILEN, 32, instruction width; only 32 is supported.
- SKID_EN, 1, 1 = 2-entry skid buffer; 0 = single entry with combinational in_ready.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous, active-low reset.
- flush_i, input, 1, discard all held entries (branch/jump redirect).
- in_valid_i, input, 1, IFU presents an instruction.
- in_ready_o, output, 1, stage can accept.
- inst_i, input, ILEN, instruction word.
- pc_i, input, XLEN, instruction address.
- out_valid_o, output, 1, decoded bundle valid.
- out_ready_i, input, 1, EXU accepts.
- pc_o, output, XLEN, registered PC.
- opcode_o, output, 7, inst[6:0].
- func3_o, output, 3, inst[14:12].
- func7_o, output, 7, inst[31:25].
- rs1_o, output, 5, inst[19:15].
- rs2_o, output, 5, inst[24:20].
- rd_o, output, 5, inst[11:7].
- imm_o, output, XLEN, sign-extended immediate.
- fmt_o, output, 6, one-hot {J,U,B,S,I,R}.
- illegal_o, output, 1, opcode not recognised.

Behaviour:
- Reset (rst low, async): state EMPTY; all outputs 0; in_ready_o = 1 after release (SKID_EN=1).
- Decode is combinational on the accepted inst; results are stored with pc, so 1-cycle latency from accept to out_valid_o.
- Format map:
  - 0110011, 0111011 -> R.
  - 0010011, 0011011, 0000011, 1100111, 1110011 -> I.
  - 0100011 -> S.
  - 1100011 -> B.
  - 0110111, 0010111 -> U.
  - 1101111 -> J.
  - Any other opcode -> fmt_o = 0, illegal_o = 1, imm_o = 0.
- Immediates (sign bit inst[31], extended to XLEN):
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
  - R: 0.
- Handshake:
  - Transfer on valid & ready.
  - out bundle is held stable while out_valid_o & !out_ready_i.
  - out_valid_o is never dropped without a transfer, except on flush.
- FSM (SKID_EN=1), main reg M drives outputs, skid reg S:
  - EMPTY: in_ready=1; accept -> ONE (load M).
  - ONE:
    - accept & out_fire -> ONE (reload M).
    - accept & !out_fire -> TWO (load S).
    - !accept & out_fire -> EMPTY.
  - TWO: in_ready=0; out_fire -> ONE (M<=S).
- in_ready_o is a registered function of state (no combinational in->out path).
- SKID_EN=0: single entry; in_ready_o = !M_valid | out_ready_i.
- Flush: next edge -> EMPTY, out_valid_o=0. An instruction offered in the flush cycle is dropped even if in_ready_o=1. Flush has priority over every other event.
- Simultaneous accept and out_fire in ONE keeps throughput at 1/cycle.
- Reset asserted mid-transfer clears everything immediately; no partial bundle is emitted.

Decomposition:
- Shared package/define header holds:
  - opcode constants.
  - FMT_* one-hot indices.
  - XLEN/ILEN defaults.
  - RstEnable (active-low) macro.
- Sub-module ysyx_22040895_imm_gen (combinational: inst -> imm, fmt, illegal) is instantiated once.
- The stage module holds the FSM and registers.

Test Plan:
- beq x1,x2,-4: inst=0xFE208EE3, pc=0x80000000 -> next cycle out_valid_o=1, fmt_o=B, rs1=1, rs2=2, imm_o=0xFFFFFFFFFFFFFFFC, pc_o=0x80000000.
- jal x1,+2048: inst=0x001000EF -> fmt_o=J, rd=1, imm_o=0x0000000000000800.
- sw x5,-8(x2) inst=0xFE512C23 -> fmt_o=S, imm_o=0xFFFFFFFFFFFFFFF8. lui x3,0x80000 inst=0x800001B7 -> fmt_o=U, imm_o=0xFFFFFFFF80000000.
- Backpressure:
  - out_ready_i=0, offer 3 back-to-back instructions -> first two accepted, in_ready_o=0 on the third.
  - Raise out_ready_i -> outputs in order A,B,C, one per cycle, with no duplicates or loss.
- Flush in state TWO with in_valid_i=1 -> next cycle out_valid_o=0, in_ready_o=1, offered instruction never appears. Illegal inst 0x0000007F -> illegal_o=1, fmt_o=0, imm_o=0.
- Drive rst low asynchronously between clock edges while state=TWO -> out_valid_o=0 immediately. After release, in_ready_o=1 and the first new instruction decodes correctly.

Source files
------------

// File: rtl/ysyx_22040895_idu_stage_pkg.sv
// Shared constants and types for the IDU decode stage.
package ysyx_22040895_idu_stage_pkg;

   localparam int unsigned IDU_XLEN = 64;
   localparam int unsigned IDU_ILEN = 32;

   // Reset is asserted when rst equals this level.
   localparam logic RST_ENABLE = 1'b0;

   // RV64 base opcodes recognised by the decoder.
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_OP_32  = 7'b0111011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   // Bit positions inside the one-hot format vector {J,U,B,S,I,R}.
   localparam int unsigned FMT_R = 0;
   localparam int unsigned FMT_I = 1;
   localparam int unsigned FMT_S = 2;
   localparam int unsigned FMT_B = 3;
   localparam int unsigned FMT_U = 4;
   localparam int unsigned FMT_J = 5;
   localparam int unsigned FMT_W = 6;

   // Occupancy of the main/skid register pair.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } idu_state_e;

endpackage

// File: rtl/ysyx_22040895_idu_stage_if.sv
// IFU-side and EXU-side handshake/bus signals of the decode stage.
interface ysyx_22040895_idu_stage_if
   import ysyx_22040895_idu_stage_pkg::*;
#(
   parameter int unsigned XLEN = IDU_XLEN,
   parameter int unsigned ILEN = IDU_ILEN
);
   logic             flush_i;
   logic             in_valid_i;
   logic             in_ready_o;
   logic [ILEN-1:0]  inst_i;
   logic [XLEN-1:0]  pc_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [XLEN-1:0]  pc_o;
   logic [6:0]       opcode_o;
   logic [2:0]       func3_o;
   logic [6:0]       func7_o;
   logic [4:0]       rs1_o;
   logic [4:0]       rs2_o;
   logic [4:0]       rd_o;
   logic [XLEN-1:0]  imm_o;
   logic [FMT_W-1:0] fmt_o;
   logic             illegal_o;

   // Decode stage view.
   modport slave (
      input  flush_i, in_valid_i, inst_i, pc_i, out_ready_i,
      output in_ready_o, out_valid_o, pc_o, opcode_o, func3_o, func7_o,
             rs1_o, rs2_o, rd_o, imm_o, fmt_o, illegal_o
   );

   // Pipeline/environment view.
   modport master (
      output flush_i, in_valid_i, inst_i, pc_i, out_ready_i,
      input  in_ready_o, out_valid_o, pc_o, opcode_o, func3_o, func7_o,
             rs1_o, rs2_o, rd_o, imm_o, fmt_o, illegal_o
   );
endinterface

// File: rtl/ysyx_22040895_imm_gen.sv
// Combinational format classifier and sign-extended immediate generator.
module ysyx_22040895_imm_gen
   import ysyx_22040895_idu_stage_pkg::*;
#(
   parameter int unsigned XLEN = IDU_XLEN,
   parameter int unsigned ILEN = IDU_ILEN
) (
   input  logic [ILEN-1:0]  i_inst,
   output logic [XLEN-1:0]  o_imm_c,
   output logic [FMT_W-1:0] o_fmt_c,
   output logic             o_illegal_c
);

   logic w_sign;
   assign w_sign = i_inst[31];

   // Opcode selects the format; unknown opcodes yield a zero immediate.
   always_comb begin
      o_imm_c     = '0;
      o_fmt_c     = '0;
      o_illegal_c = 1'b0;
      case (i_inst[6:0])
         OP_OP, OP_OP_32: o_fmt_c[FMT_R] = 1'b1;
         OP_IMM, OP_IMM_32, OP_LOAD, OP_JALR, OP_SYSTEM: begin
            o_fmt_c[FMT_I] = 1'b1;
            o_imm_c = {{(XLEN-12){w_sign}}, i_inst[31:20]};
         end
         OP_STORE: begin
            o_fmt_c[FMT_S] = 1'b1;
            o_imm_c = {{(XLEN-12){w_sign}}, i_inst[31:25], i_inst[11:7]};
         end
         OP_BRANCH: begin
            o_fmt_c[FMT_B] = 1'b1;
            o_imm_c = {{(XLEN-13){w_sign}}, i_inst[31], i_inst[7],
                       i_inst[30:25], i_inst[11:8], 1'b0};
         end
         OP_LUI, OP_AUIPC: begin
            o_fmt_c[FMT_U] = 1'b1;
            o_imm_c = {{(XLEN-32){w_sign}}, i_inst[31:12], 12'b0};
         end
         OP_JAL: begin
            o_fmt_c[FMT_J] = 1'b1;
            o_imm_c = {{(XLEN-21){w_sign}}, i_inst[31], i_inst[19:12],
                       i_inst[20], i_inst[30:21], 1'b0};
         end
         default: o_illegal_c = 1'b1;
      endcase
   end

endmodule

// File: rtl/ysyx_22040895_idu_stage.sv
// Registered decode stage with a 2-entry skid buffer between IFU and EXU.
module ysyx_22040895_idu_stage
   import ysyx_22040895_idu_stage_pkg::*;
#(
   parameter int unsigned XLEN    = IDU_XLEN,
   parameter int unsigned ILEN    = IDU_ILEN,
   parameter bit          SKID_EN = 1'b1
) (
   input logic                     clk,
   input logic                     rst,
   ysyx_22040895_idu_stage_if.slave bus
);

   typedef struct packed {
      logic [XLEN-1:0]  pc;
      logic [6:0]       opcode;
      logic [2:0]       func3;
      logic [6:0]       func7;
      logic [4:0]       rs1;
      logic [4:0]       rs2;
      logic [4:0]       rd;
      logic [XLEN-1:0]  imm;
      logic [FMT_W-1:0] fmt;
      logic             illegal;
   } bundle_t;

   idu_state_e       r_state;
   idu_state_e       w_state_nxt;
   logic             r_out_valid;
   bundle_t          r_m;
   bundle_t          r_s;
   bundle_t          w_dec;
   logic [ILEN-1:0]  w_inst;
   logic [XLEN-1:0]  w_imm;
   logic [FMT_W-1:0] w_fmt;
   logic             w_illegal;
   logic             w_in_ready;
   logic             w_accept;
   logic             w_out_fire;
   logic             w_load_m;
   logic             w_m_from_s;
   logic             w_load_s;

   assign w_inst = bus.inst_i;

   ysyx_22040895_imm_gen #(.XLEN(XLEN), .ILEN(ILEN)) u_imm_gen (
      .i_inst      (w_inst),
      .o_imm_c     (w_imm),
      .o_fmt_c     (w_fmt),
      .o_illegal_c (w_illegal)
   );

   // Assemble the decoded bundle for the instruction currently offered.
   always_comb begin
      w_dec         = '0;
      w_dec.pc      = bus.pc_i;
      w_dec.opcode  = w_inst[6:0];
      w_dec.func3   = w_inst[14:12];
      w_dec.func7   = w_inst[31:25];
      w_dec.rs1     = w_inst[19:15];
      w_dec.rs2     = w_inst[24:20];
      w_dec.rd      = w_inst[11:7];
      w_dec.imm     = w_imm;
      w_dec.fmt     = w_fmt;
      w_dec.illegal = w_illegal;
   end

   // A flush cycle never accepts, even when ready is high.
   assign w_accept   = bus.in_valid_i & w_in_ready & ~bus.flush_i;
   assign w_out_fire = r_out_valid & bus.out_ready_i;

   if (SKID_EN) begin : g_skid
      logic r_in_ready;
      // Ready is a registered function of the next occupancy.
      always_ff @(posedge clk or negedge rst) begin
         if (rst == RST_ENABLE) r_in_ready <= 1'b0;
         else                   r_in_ready <= (w_state_nxt != ST_TWO);
      end
      assign bus.in_ready_o = r_in_ready;
   end else begin : g_single
      assign bus.in_ready_o = ~r_out_valid | bus.out_ready_i;
   end
   assign w_in_ready = bus.in_ready_o;

   // State register and registered output valid.
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ENABLE) begin
         r_state     <= ST_EMPTY;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_out_valid <= (w_state_nxt != ST_EMPTY);
      end
   end

   // Next-state logic; flush overrides every other event.
   always_comb begin
      w_state_nxt = r_state;
      if (bus.flush_i) begin
         w_state_nxt = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: if (w_accept) w_state_nxt = ST_ONE;
            ST_ONE: begin
               if (w_accept && !w_out_fire)      w_state_nxt = SKID_EN ? ST_TWO : ST_ONE;
               else if (!w_accept && w_out_fire) w_state_nxt = ST_EMPTY;
            end
            ST_TWO:  if (w_out_fire) w_state_nxt = ST_ONE;
            default: w_state_nxt = ST_EMPTY;
         endcase
      end
   end

   // Register load controls for main and skid entries.
   always_comb begin
      w_load_m   = 1'b0;
      w_m_from_s = 1'b0;
      w_load_s   = 1'b0;
      if (!bus.flush_i) begin
         case (r_state)
            ST_EMPTY: w_load_m = w_accept;
            ST_ONE: begin
               if (w_accept && w_out_fire) w_load_m = 1'b1;
               else if (w_accept)          w_load_s = SKID_EN;
            end
            ST_TWO: begin
               w_load_m   = w_out_fire;
               w_m_from_s = w_out_fire;
            end
            default: ;
         endcase
      end
   end

   // Main and skid payload registers.
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ENABLE) begin
         r_m <= '0;
         r_s <= '0;
      end else begin
         if (w_load_m) r_m <= w_m_from_s ? r_s : w_dec;
         if (w_load_s) r_s <= w_dec;
      end
   end

   assign bus.out_valid_o = r_out_valid;
   assign bus.pc_o        = r_m.pc;
   assign bus.opcode_o    = r_m.opcode;
   assign bus.func3_o     = r_m.func3;
   assign bus.func7_o     = r_m.func7;
   assign bus.rs1_o       = r_m.rs1;
   assign bus.rs2_o       = r_m.rs2;
   assign bus.rd_o        = r_m.rd;
   assign bus.imm_o       = r_m.imm;
   assign bus.fmt_o       = r_m.fmt;
   assign bus.illegal_o   = r_m.illegal;

endmodule

// File: tb/tb_ysyx_22040895_idu_stage.sv
// Self-checking bench: directed decode cases, backpressure, flush, async reset, random traffic.
module tb_ysyx_22040895_idu_stage;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] inst;
      logic [63:0] imm;
      logic [5:0]  fmt;
      logic        illegal;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   bit   fresh;
   exp_t q[$];
   logic [6:0]  ops [12];
   logic [31:0] w;

   ysyx_22040895_idu_stage_if #(.XLEN(64), .ILEN(32)) bus ();

   ysyx_22040895_idu_stage #(.XLEN(64), .ILEN(32), .SKID_EN(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference decode from the instruction-set rules, using signed arithmetic.
   function automatic exp_t ref_decode(input logic [31:0] inst, input logic [63:0] pc);
      exp_t   e;
      longint sx;
      longint hi;
      sx = longint'($signed(inst));
      e.pc = pc; e.inst = inst; e.imm = '0; e.fmt = '0; e.illegal = 1'b0;
      case (inst[6:0])
         7'h33, 7'h3B: e.fmt = 6'b000001;
         7'h13, 7'h1B, 7'h03, 7'h67, 7'h73: begin
            e.fmt = 6'b000010; hi = sx >>> 20; e.imm = hi;
         end
         7'h23: begin
            e.fmt = 6'b000100; hi = (sx >>> 25) * 32;
            e.imm = hi + longint'(inst[11:7]);
         end
         7'h63: begin
            e.fmt = 6'b001000; hi = (sx >>> 31) * 4096;
            e.imm = hi + longint'(inst[7]) * 2048 + longint'(inst[30:25]) * 32
                    + longint'(inst[11:8]) * 2;
         end
         7'h37, 7'h17: begin
            e.fmt = 6'b010000; hi = (sx >>> 12) * 4096; e.imm = hi;
         end
         7'h6F: begin
            e.fmt = 6'b100000; hi = (sx >>> 31) * 1048576;
            e.imm = hi + longint'(inst[19:12]) * 4096 + longint'(inst[20]) * 2048
                    + longint'(inst[30:21]) * 2;
         end
         default: e.illegal = 1'b1;
      endcase
      return e;
   endfunction

   task automatic cmp_bundle(input exp_t e);
      chk("pc", bus.pc_o, e.pc);
      chk("fields", 64'({bus.func7_o, bus.rs2_o, bus.rs1_o, bus.func3_o, bus.rd_o, bus.opcode_o}),
          64'(e.inst));
      chk("imm", bus.imm_o, e.imm);
      chk("fmt", 64'(bus.fmt_o), 64'(e.fmt));
      chk("illegal", 64'(bus.illegal_o), 64'(e.illegal));
   endtask

   // One clock with inputs already driven; checks occupancy and outgoing data against the model.
   task automatic cycle();
      exp_t e;
      bit   in_fire;
      bit   out_fire;
      #1;
      if (!fresh) chk("in_ready", 64'(bus.in_ready_o), 64'(q.size() < 2));
      chk("out_valid", 64'(bus.out_valid_o), 64'(q.size() != 0));
      chk("occupancy", 64'(q.size() <= 2), 64'(1));
      in_fire  = bus.in_valid_i & bus.in_ready_o & ~bus.flush_i;
      out_fire = bus.out_valid_o & bus.out_ready_i;
      if (out_fire && q.size() != 0) begin
         e = q.pop_front();
         cmp_bundle(e);
      end
      if (bus.flush_i)  q.delete();
      else if (in_fire) q.push_back(ref_decode(bus.inst_i, bus.pc_i));
      @(posedge clk);
      fresh = 1'b0;
      @(negedge clk);
   endtask

   task automatic offer(input logic [31:0] inst, input logic [63:0] pc);
      bus.in_valid_i = 1'b1; bus.inst_i = inst; bus.pc_i = pc;
      cycle();
      bus.in_valid_i = 1'b0;
   endtask

   task automatic directed(input logic [31:0] inst, input logic [63:0] pc, input logic [63:0] imm,
                           input logic [5:0] fmt, input logic ill, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [4:0] rd);
      bus.out_ready_i = 1'b0;
      offer(inst, pc);
      #1;
      chk("dir_valid", 64'(bus.out_valid_o), 64'(1));
      chk("dir_pc", bus.pc_o, pc);
      chk("dir_imm", bus.imm_o, imm);
      chk("dir_fmt", 64'(bus.fmt_o), 64'(fmt));
      chk("dir_illegal", 64'(bus.illegal_o), 64'(ill));
      chk("dir_regs", 64'({bus.rs1_o, bus.rs2_o, bus.rd_o}), 64'({rs1, rs2, rd}));
      bus.out_ready_i = 1'b1;
      cycle();
      bus.out_ready_i = 1'b0;
   endtask

   initial begin
      checks = 0; failures = 0; fresh = 1'b1;
      ops = '{7'h33, 7'h3B, 7'h13, 7'h1B, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
      rst = 1'b0;
      bus.flush_i = 1'b0; bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b0;
      bus.inst_i = '0; bus.pc_i = '0;

      // Reset state.
      @(negedge clk);
      chk("rst_out_valid", 64'(bus.out_valid_o), 64'(0));
      chk("rst_in_ready", 64'(bus.in_ready_o), 64'(0));
      chk("rst_pc", bus.pc_o, 64'(0));
      chk("rst_imm", bus.imm_o, 64'(0));
      @(negedge clk);
      rst = 1'b1;
      cycle();
      chk("post_rst_in_ready", 64'(bus.in_ready_o), 64'(1));

      // Directed decodes.
      directed(32'hFE208EE3, 64'h80000000, 64'hFFFFFFFFFFFFFFFC, 6'b001000, 1'b0, 5'd1, 5'd2, 5'd29);
      directed(32'h001000EF, 64'h80000004, 64'h0000000000000800, 6'b100000, 1'b0, 5'd0, 5'd1, 5'd1);
      directed(32'hFE512C23, 64'h80000008, 64'hFFFFFFFFFFFFFFF8, 6'b000100, 1'b0, 5'd2, 5'd5, 5'd24);
      directed(32'h800001B7, 64'h8000000C, 64'hFFFFFFFF80000000, 6'b010000, 1'b0, 5'd0, 5'd0, 5'd3);
      directed(32'h0000007F, 64'h80000010, 64'h0, 6'b000000, 1'b1, 5'd0, 5'd0, 5'd0);

      // Backpressure: A and B accepted, C stalls until a slot frees.
      bus.out_ready_i = 1'b0; bus.in_valid_i = 1'b1;
      bus.inst_i = 32'h00100093; bus.pc_i = 64'h100; cycle();
      bus.inst_i = 32'h00200113; bus.pc_i = 64'h104; cycle();
      bus.inst_i = 32'h00300193; bus.pc_i = 64'h108;
      #1 chk("bp_third_stall", 64'(bus.in_ready_o), 64'(0));
      bus.out_ready_i = 1'b1;
      cycle(); cycle();
      bus.in_valid_i = 1'b0;
      cycle(); cycle();
      chk("bp_drained", 64'(q.size()), 64'(0));

      // Flush while holding two entries with a new instruction offered.
      bus.out_ready_i = 1'b0;
      offer(32'h00400213, 64'h200); offer(32'h00500293, 64'h204);
      bus.flush_i = 1'b1; bus.in_valid_i = 1'b1; bus.inst_i = 32'h00600313; bus.pc_i = 64'h208;
      cycle();
      bus.flush_i = 1'b0; bus.in_valid_i = 1'b0;
      #1;
      chk("flush_out_valid", 64'(bus.out_valid_o), 64'(0));
      chk("flush_in_ready", 64'(bus.in_ready_o), 64'(1));
      bus.out_ready_i = 1'b1;
      cycle(); cycle();

      // Flush in the one-entry state drops an instruction even though ready is high.
      bus.out_ready_i = 1'b0;
      offer(32'h00700393, 64'h300);
      bus.flush_i = 1'b1; bus.in_valid_i = 1'b1; bus.inst_i = 32'h00800413; bus.pc_i = 64'h304;
      cycle();
      bus.flush_i = 1'b0; bus.in_valid_i = 1'b0;
      cycle();

      // Asynchronous reset while two entries are held.
      offer(32'h00900493, 64'h400); offer(32'h00A00513, 64'h404);
      #2 rst = 1'b0;
      #1;
      chk("arst_out_valid", 64'(bus.out_valid_o), 64'(0));
      chk("arst_in_ready", 64'(bus.in_ready_o), 64'(0));
      chk("arst_pc", bus.pc_o, 64'(0));
      q.delete();
      @(negedge clk); @(negedge clk);
      rst = 1'b1; fresh = 1'b1;
      cycle();
      chk("arst_release_ready", 64'(bus.in_ready_o), 64'(1));
      directed(32'hFE208EE3, 64'h80001000, 64'hFFFFFFFFFFFFFFFC, 6'b001000, 1'b0, 5'd1, 5'd2, 5'd29);

      // Random traffic against the reference queue.
      for (int i = 0; i < 600; i++) begin
         bus.in_valid_i  = ($urandom_range(0, 3) != 0);
         bus.out_ready_i = ($urandom_range(0, 2) != 0);
         bus.flush_i     = ($urandom_range(0, 24) == 0);
         w = $urandom;
         if ($urandom_range(0, 4) != 0) w[6:0] = ops[$urandom_range(0, 11)];
         bus.inst_i = w;
         bus.pc_i   = {$urandom, $urandom};
         cycle();
      end
      bus.in_valid_i = 1'b0; bus.flush_i = 1'b0; bus.out_ready_i = 1'b1;
      cycle(); cycle(); cycle();
      chk("final_drained", 64'(q.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
